multicycle_main_control: RTL and testbench

- Multicycle main control FSM for the phase-2 MIPS-subset datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, and produces the 3-bit alu_op consumed by the ALU control decoder.
- Handles variable-latency memory through a ready handshake with a timeout, and traps illegal opcodes.

---
 rtl/multicycle_main_control.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM for the MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/writeback, drives every datapath
// enable and mux select, waits on a memory ready handshake with a timeout
// trap, and traps unsupported opcodes.
// Optional: define J_EN to add the J instruction (opcode 000010).
module multicycle_main_control #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] state_o
);

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
`ifdef J_EN
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
`endif

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        R_WB     = 4'd8,
        EXEC_I   = 4'd9,
        I_WB     = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        TRAP     = 4'd13
    } state_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            bus_error_q, bus_error_d;
    logic            timeout_c;
    logic            mem_state_c;

    // A memory-wait state times out when the counter hits the limit with no ready.
    assign timeout_c = (WAIT_LIMIT != 0) && (cnt_q == CNT_W'(WAIT_LIMIT)) && !mem_ready;
    assign mem_state_c = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
    assign state_o   = state_q;

    // State, latched opcode, wait counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Next-state and control decode; Moore outputs plus the ready/zero terms.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = '0;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 3'b000;
        pc_src      = 2'b00;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b001;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (timeout_c) begin
                    state_d     = TRAP;
                    bus_error_d = 1'b1;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b001;
                op_d      = opcode;
                case (opcode)
                    OP_R:                              state_d = EXEC_R;
                    OP_LW, OP_SW:                      state_d = MEM_ADDR;
                    OP_BEQ:                            state_d = BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = EXEC_I;
`ifdef J_EN
                    OP_J:                              state_d = JUMP;
`endif
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b001;
                state_d   = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = MEM_WB;
                end else if (timeout_c) begin
                    state_d     = TRAP;
                    bus_error_d = 1'b1;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else if (timeout_c) begin
                    state_d     = TRAP;
                    bus_error_d = 1'b1;
                end
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b111;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_ADDI: alu_op = 3'b101;
                    OP_SLTI: alu_op = 3'b100;
                    OP_ANDI: alu_op = 3'b011;
                    OP_ORI:  alu_op = 3'b010;
                    default: alu_op = 3'b000;
                endcase
                state_d = I_WB;
            end
            I_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                pc_write  = zero;
                state_d   = FETCH;
            end
`ifdef J_EN
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                state_d  = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase

        // Count consecutive cycles spent waiting in a memory state.
        if (mem_state_c && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: instructions are expanded into a
// per-cycle plan of stimulus and expected controls, then replayed.
module tb_multicycle_main_control;

    localparam int LIMIT = 15;
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                   S_MEM_RD = 4, S_MEM_WB = 5, S_MEM_WR = 6, S_EXEC_R = 7,
                   S_R_WB = 8, S_EXEC_I = 9, S_I_WB = 10, S_BRANCH = 11,
                   S_JUMP = 12, S_TRAP = 13;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal, bus_error;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_main_control #(.WAIT_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .illegal(illegal), .bus_error(bus_error),
        .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, iod, mrd, mwr, rw, rdst, m2r, asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] psrc;
        logic       ill, berr;
    } ctl_t;

    typedef struct packed {
        ctl_t       exp;
        logic       rst, mr, z;
        logic [5:0] op;
    } step_t;

    step_t      plan[$];
    logic       ill_m, berr_m;
    logic [5:0] op_lat;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    // Control values each phase must present, straight from the control table.
    function automatic ctl_t expect_ctl(int st, logic mr, logic z, logic [5:0] opq);
        ctl_t c;
        c = '0;
        c.st = 4'(st);
        case (st)
            S_FETCH:    begin c.mrd = 1; c.asb = 2'b01; c.aop = 3'b001; c.irw = mr; c.pcw = mr; end
            S_DECODE:   begin c.asb = 2'b11; c.aop = 3'b001; end
            S_MEM_ADDR: begin c.asa = 1; c.asb = 2'b10; c.aop = 3'b001; end
            S_MEM_RD:   begin c.mrd = 1; c.iod = 1; end
            S_MEM_WB:   begin c.rw = 1; c.m2r = 1; end
            S_MEM_WR:   begin c.mwr = 1; c.iod = 1; end
            S_EXEC_R:   begin c.asa = 1; c.aop = 3'b111; end
            S_R_WB:     begin c.rw = 1; c.rdst = 1; end
            S_EXEC_I: begin
                c.asa = 1; c.asb = 2'b10;
                if (opq == 6'b001000) c.aop = 3'b101;
                else if (opq == 6'b001010) c.aop = 3'b100;
                else if (opq == 6'b001100) c.aop = 3'b011;
                else c.aop = 3'b010;
            end
            S_I_WB:     c.rw = 1;
            S_BRANCH:   begin c.asa = 1; c.psrc = 2'b01; c.pcw = z; end
            S_JUMP:     begin c.pcw = 1; c.psrc = 2'b10; end
            default:    ;
        endcase
        return c;
    endfunction

    task automatic push(input int st, input logic mr, input logic z, input logic [5:0] op, input logic rst);
        step_t s;
        s.exp      = expect_ctl(st, mr, z, op_lat);
        s.exp.ill  = ill_m;
        s.exp.berr = berr_m;
        s.rst = rst; s.mr = mr; s.z = z; s.op = op;
        plan.push_back(s);
    endtask

    // A memory phase with w not-ready cycles; more than LIMIT ends in a bus-error trap.
    task automatic mem_phase(input int st, input int w, output bit trapped);
        trapped = 0;
        if (w <= LIMIT) begin
            for (int i = 0; i < w; i++) push(st, 1'b0, rbit(), rop(), 1'b1);
            push(st, 1'b1, rbit(), rop(), 1'b1);
        end else begin
            for (int i = 0; i < LIMIT + 1; i++) push(st, 1'b0, rbit(), rop(), 1'b1);
            berr_m = 1'b1;
            push(S_TRAP, rbit(), rbit(), rop(), 1'b1);
            trapped = 1;
        end
    endtask

    // One instruction: fetch (retried after timeouts), decode, then its own phases.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
        bit tr;
        int w;
        w = fw;
        do begin
            mem_phase(S_FETCH, w, tr);
            if (tr) w -= LIMIT + 1;
        end while (tr);
        push(S_DECODE, rbit(), rbit(), op, 1'b1);
        op_lat = op;
        case (op)
            6'b000000: begin push(S_EXEC_R, rbit(), rbit(), rop(), 1'b1); push(S_R_WB, rbit(), rbit(), rop(), 1'b1); end
            6'b100011: begin
                push(S_MEM_ADDR, rbit(), rbit(), rop(), 1'b1);
                mem_phase(S_MEM_RD, mw, tr);
                if (!tr) push(S_MEM_WB, rbit(), rbit(), rop(), 1'b1);
            end
            6'b101011: begin
                push(S_MEM_ADDR, rbit(), rbit(), rop(), 1'b1);
                mem_phase(S_MEM_WR, mw, tr);
            end
            6'b000100: push(S_BRANCH, rbit(), z, rop(), 1'b1);
            6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
                push(S_EXEC_I, rbit(), rbit(), rop(), 1'b1);
                push(S_I_WB, rbit(), rbit(), rop(), 1'b1);
            end
`ifdef J_EN
            6'b000010: push(S_JUMP, rbit(), rbit(), rop(), 1'b1);
`endif
            default: begin
                ill_m = 1'b1;
                push(S_TRAP, rbit(), rbit(), rop(), 1'b1);
            end
        endcase
    endtask

    // Reset asserted during DECODE of an illegal opcode; sticky flags must clear.
    task automatic reset_mid();
        push(S_FETCH, 1'b1, rbit(), rop(), 1'b1);
        push(S_DECODE, rbit(), rbit(), 6'b111111, 1'b0);
        ill_m  = 1'b0;
        berr_m = 1'b0;
        push(S_IDLE, rbit(), rbit(), rop(), 1'b1);
    endtask

    function automatic int rwait();
        if ($urandom_range(0, 19) == 0) return int'($urandom_range(14, 20));
        return int'($urandom_range(0, 2));
    endfunction

    initial begin
        logic [5:0] ops[10];
        ctl_t       o;
        int         k;

        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
        ops[4] = 6'b001000; ops[5] = 6'b001010; ops[6] = 6'b001100; ops[7] = 6'b001101;
        ops[8] = 6'b000010; ops[9] = 6'b111111;

        rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        ill_m = 1'b0; berr_m = 1'b0; op_lat = '0;

        // Reset held two edges, then released while still in IDLE.
        push(S_IDLE, 1'b1, 1'b0, 6'd0, 1'b0);
        push(S_IDLE, 1'b1, 1'b0, 6'd0, 1'b0);
        push(S_IDLE, 1'b1, 1'b0, 6'd0, 1'b1);

        run_instr(6'b000000, 1'b0, 0, 0);
        run_instr(6'b100011, 1'b0, 0, 3);
        run_instr(6'b000100, 1'b1, 0, 0);
        run_instr(6'b000100, 1'b0, 0, 0);
        run_instr(6'b101011, 1'b0, 1, 2);
        run_instr(6'b001101, 1'b0, 0, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(6'b001000, 1'b0, 0, 0);
        run_instr(6'b100011, 1'b0, 0, LIMIT);
        run_instr(6'b001010, 1'b0, LIMIT + 1, 0);
        run_instr(6'b101011, 1'b0, 0, LIMIT + 1);
        run_instr(6'b000010, 1'b0, 0, 0);
        reset_mid();

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                reset_mid();
            end else begin
                k = int'($urandom_range(0, 11));
                run_instr((k < 10) ? ops[k] : rop(), rbit(), rwait(), rwait());
            end
        end

        @(posedge clk);
        for (int i = 0; i < plan.size(); i++) begin
            #1;
            rst_n     = plan[i].rst;
            mem_ready = plan[i].mr;
            zero      = plan[i].z;
            opcode    = plan[i].op;
            @(negedge clk);
            o.st = state_o;   o.pcw = pc_write;  o.irw = ir_write;  o.iod = i_or_d;
            o.mrd = mem_read; o.mwr = mem_write; o.rw = reg_write;  o.rdst = reg_dst;
            o.m2r = mem_to_reg; o.asa = alu_src_a; o.asb = alu_src_b; o.aop = alu_op;
            o.psrc = pc_src;  o.ill = illegal;   o.berr = bus_error;
            check_val($sformatf("cyc%0d_st%0d", i, plan[i].exp.st), 32'(o), 32'(plan[i].exp));
            @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
